// File: rtl/uart_fifo_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_core_if
//  Purpose  : CPU-side strobe/status bundle of the FIFO-buffered UART core.
//  Revision : 1.0
// ============================================================================
interface uart_fifo_core_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_wr;
    logic                 tx_full;
    logic [FIFO_AW:0]     tx_count;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_rd;
    logic                 rx_empty;
    logic [FIFO_AW:0]     rx_count;
    logic                 err_clr;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 irq;

    modport master (
        output tx_data, tx_wr, rx_rd, err_clr,
        input  tx_full, tx_count, rx_data, rx_empty, rx_count,
               frame_err, parity_err, overrun, irq
    );

    modport slave (
        input  tx_data, tx_wr, rx_rd, err_clr,
        output tx_full, tx_count, rx_data, rx_empty, rx_count,
               frame_err, parity_err, overrun, irq
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_core
//  Purpose  : UART transceiver with internal oversample tick, 16x RX, optional
//             parity, TX/RX FIFOs and sticky error flags.
//  Revision : 1.0
// ============================================================================
module uart_fifo_core #(
    parameter int OS_DIV    = 326,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int FIFO_AW   = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       uart_rx,
    output logic            uart_tx,
    uart_fifo_core_if.slave bus
);
    localparam int                  c_DEPTH    = 2 ** FIFO_AW;
    localparam int                  c_DIV_W    = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int                  c_BIT_W    = $clog2(DATA_BITS);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(OS_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [FIFO_AW:0]    c_FULL     = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic                c_HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------ tick
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;

    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // --------------------------------------------------------------- TX FIFO
    logic [DATA_BITS-1:0] r_tx_mem [c_DEPTH];
    logic [FIFO_AW-1:0]   r_tx_wp, r_tx_rp;
    logic [FIFO_AW:0]     r_tx_cnt;
    logic                 w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_tx_push = bus.tx_wr && (r_tx_cnt != c_FULL);
    assign w_tx_head = r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.tx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------------- TX FSM
    state_t               r_tx_state, w_tx_state_nxt;
    logic [3:0]           r_tx_tcnt, w_tx_tcnt_nxt;
    logic [c_BIT_W-1:0]   r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 r_uart_tx, w_tx_line_nxt;
    logic                 w_tx_bit_end;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_tcnt  <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx_par   <= 1'b0;
            r_uart_tx  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_tcnt  <= w_tx_tcnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_uart_tx  <= w_tx_line_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_tcnt_nxt  = r_tx_tcnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_sh_nxt    = r_tx_sh;
        w_tx_par_nxt   = r_tx_par;
        w_tx_pop       = 1'b0;
        w_tx_line_nxt  = 1'b1;
        w_tx_bit_end   = w_tick && (r_tx_tcnt == 4'hF);

        if (w_tick && (r_tx_state != S_IDLE)) w_tx_tcnt_nxt = r_tx_tcnt + 1'b1;

        case (r_tx_state)
            S_START: if (w_tx_bit_end) begin
                w_tx_state_nxt = S_DATA;
                w_tx_bit_nxt   = '0;
            end
            S_DATA: if (w_tx_bit_end) begin
                w_tx_sh_nxt = r_tx_sh >> 1;
                if (r_tx_bit == c_BIT_LAST) w_tx_state_nxt = c_HAS_PAR ? S_PARITY : S_STOP;
                else                        w_tx_bit_nxt   = r_tx_bit + 1'b1;
            end
            S_PARITY: if (w_tx_bit_end) w_tx_state_nxt = S_STOP;
            S_STOP:   if (w_tx_bit_end) w_tx_state_nxt = S_IDLE;
            default:  w_tx_state_nxt = S_IDLE;
        endcase

        // The last stop tick can launch the next frame directly, so back-to-back bytes have no gap
        if (w_tick && (r_tx_cnt != '0) &&
            ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && (r_tx_tcnt == 4'hF)))) begin
            w_tx_pop       = 1'b1;
            w_tx_state_nxt = S_START;
            w_tx_tcnt_nxt  = '0;
            w_tx_sh_nxt    = w_tx_head;
            w_tx_par_nxt   = (PARITY == 1) ? ~^w_tx_head : ^w_tx_head;
        end

        case (w_tx_state_nxt)
            S_START:  w_tx_line_nxt = 1'b0;
            S_DATA:   w_tx_line_nxt = w_tx_sh_nxt[0];
            S_PARITY: w_tx_line_nxt = w_tx_par_nxt;
            default:  w_tx_line_nxt = 1'b1;
        endcase
    end

    assign uart_tx = r_uart_tx;

    // ---------------------------------------------------------------- RX FSM
    logic                 r_rx_s1, r_rx_s2;
    state_t               r_rx_state, w_rx_state_nxt;
    logic [3:0]           r_rx_tcnt, w_rx_tcnt_nxt;
    logic [c_BIT_W-1:0]   r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_nxt;
    logic                 r_rx_parbit, w_rx_parbit_nxt;
    logic                 w_rx_done, w_rx_mid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_state  <= S_IDLE;
            r_rx_tcnt   <= '0;
            r_rx_bit    <= '0;
            r_rx_sh     <= '0;
            r_rx_parbit <= 1'b0;
        end else begin
            r_rx_s1     <= uart_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_state  <= w_rx_state_nxt;
            r_rx_tcnt   <= w_rx_tcnt_nxt;
            r_rx_bit    <= w_rx_bit_nxt;
            r_rx_sh     <= w_rx_sh_nxt;
            r_rx_parbit <= w_rx_parbit_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt  = r_rx_state;
        w_rx_tcnt_nxt   = r_rx_tcnt;
        w_rx_bit_nxt    = r_rx_bit;
        w_rx_sh_nxt     = r_rx_sh;
        w_rx_parbit_nxt = r_rx_parbit;
        w_rx_done       = 1'b0;
        w_rx_mid        = w_tick && (r_rx_tcnt == 4'hF);

        if (w_tick) w_rx_tcnt_nxt = r_rx_tcnt + 1'b1;

        case (r_rx_state)
            S_IDLE: begin
                w_rx_tcnt_nxt = '0;
                if (w_tick && !r_rx_s2) w_rx_state_nxt = S_START;
            end
            // Mid start bit: a line already back high was only a glitch
            S_START: if (w_tick && (r_rx_tcnt == 4'd7)) begin
                w_rx_tcnt_nxt  = '0;
                w_rx_bit_nxt   = '0;
                w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_mid) begin
                w_rx_sh_nxt = {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                if (r_rx_bit == c_BIT_LAST) w_rx_state_nxt = c_HAS_PAR ? S_PARITY : S_STOP;
                else                        w_rx_bit_nxt   = r_rx_bit + 1'b1;
            end
            S_PARITY: if (w_rx_mid) begin
                w_rx_parbit_nxt = r_rx_s2;
                w_rx_state_nxt  = S_STOP;
            end
            S_STOP: if (w_rx_mid) begin
                w_rx_done      = 1'b1;
                w_rx_state_nxt = S_IDLE;
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase
    end

    // --------------------------------------------------- RX verdict and FIFO
    logic                 w_par_bad, w_frame_set, w_par_set, w_rx_good, w_rx_push, w_ovr_set, w_rx_pop;
    logic [DATA_BITS-1:0] r_rx_mem [c_DEPTH];
    logic [FIFO_AW-1:0]   r_rx_wp, r_rx_rp;
    logic [FIFO_AW:0]     r_rx_cnt;
    logic                 r_frame_err, r_parity_err, r_overrun, r_irq;

    assign w_par_bad   = c_HAS_PAR && ((^{r_rx_sh, r_rx_parbit}) != (PARITY == 1));
    assign w_frame_set = w_rx_done && !r_rx_s2;
    assign w_par_set   = w_rx_done && w_par_bad;
    assign w_rx_good   = w_rx_done && r_rx_s2 && !w_par_bad;
    assign w_rx_push   = w_rx_good && (r_rx_cnt != c_FULL);
    assign w_ovr_set   = w_rx_good && (r_rx_cnt == c_FULL);
    assign w_rx_pop    = bus.rx_rd && (r_rx_cnt != '0);

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_wp      <= '0;
            r_rx_rp      <= '0;
            r_rx_cnt     <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            // A set event in the same cycle as err_clr keeps the flag
            r_frame_err  <= w_frame_set | (r_frame_err  & ~bus.err_clr);
            r_parity_err <= w_par_set   | (r_parity_err & ~bus.err_clr);
            r_overrun    <= w_ovr_set   | (r_overrun    & ~bus.err_clr);
            r_irq        <= (r_rx_cnt != '0) | r_frame_err | r_parity_err | r_overrun;
        end
    end

    assign bus.tx_full    = (r_tx_cnt == c_FULL);
    assign bus.tx_count   = r_tx_cnt;
    assign bus.rx_empty   = (r_rx_cnt == '0);
    assign bus.rx_count   = r_rx_cnt;
    assign bus.rx_data    = (r_rx_cnt == '0) ? '0 : r_rx_mem[r_rx_rp];
    assign bus.frame_err  = r_frame_err;
    assign bus.parity_err = r_parity_err;
    assign bus.overrun    = r_overrun;
    assign bus.irq        = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo_core
//  Purpose  : Directed self-checking bench: loopback, FIFO limits, error
//             flags, parity and mid-frame reset of uart_fifo_core.
//  Revision : 1.0
// ============================================================================
module tb_uart_fifo_core;
    localparam int OS_DIV   = 4;
    localparam int BIT_CLKS = 16 * OS_DIV;

    logic clk = 1'b0;
    logic reset;
    logic uart_tx0, uart_rx0, uart_tx1;
    logic drv0, drv1, rx_src;
    int   n_vec = 0;
    int   n_err = 0;

    uart_fifo_core_if #(.DATA_BITS(8), .FIFO_AW(2)) bus0 ();
    uart_fifo_core_if #(.DATA_BITS(8), .FIFO_AW(2)) bus1 ();

    // dut0: no parity, loopback or bench-driven RX; dut1: even parity, bench-driven RX
    assign uart_rx0 = rx_src ? drv0 : uart_tx0;

    uart_fifo_core #(.OS_DIV(OS_DIV), .DATA_BITS(8), .PARITY(0), .FIFO_AW(2)) dut0 (
        .clk(clk), .reset(reset), .uart_rx(uart_rx0), .uart_tx(uart_tx0), .bus(bus0));
    uart_fifo_core #(.OS_DIV(OS_DIV), .DATA_BITS(8), .PARITY(2), .FIFO_AW(2)) dut1 (
        .clk(clk), .reset(reset), .uart_rx(drv1), .uart_tx(uart_tx1), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d);
        bus0.tx_data = d;
        bus0.tx_wr   = 1'b1;
        @(negedge clk);
        bus0.tx_wr   = 1'b0;
    endtask

    task automatic pop_check0(input string tag, input logic [7:0] exp);
        check(tag, bus0.rx_data, exp);
        bus0.rx_rd = 1'b1;
        @(negedge clk);
        bus0.rx_rd = 1'b0;
    endtask

    task automatic pulse_clr0();
        bus0.err_clr = 1'b1;
        @(negedge clk);
        bus0.err_clr = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (uart_tx0 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, uart_tx0, 1'b0);
    endtask

    task automatic drive_rx(input bit to_dut1, input logic b);
        if (to_dut1) drv1 = b;
        else         drv0 = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input bit to_dut1, input logic [7:0] d, input bit with_par,
                              input logic par, input logic stop);
        drive_rx(to_dut1, 1'b0);
        for (int i = 0; i < 8; i++) drive_rx(to_dut1, d[i]);
        if (with_par) drive_rx(to_dut1, par);
        drive_rx(to_dut1, stop);
        drive_rx(to_dut1, 1'b1);
    endtask

    initial begin
        logic [7:0] bytes1 [4];
        logic [7:0] cur;
        logic [7:0] a5;
        logic       exp_bit;

        reset = 1'b0;
        drv0 = 1'b1; drv1 = 1'b1; rx_src = 1'b0;
        bus0.tx_data = '0; bus0.tx_wr = 1'b0; bus0.rx_rd = 1'b0; bus0.err_clr = 1'b0;
        bus1.tx_data = '0; bus1.tx_wr = 1'b0; bus1.rx_rd = 1'b0; bus1.err_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_uart_tx", uart_tx0, 1'b1);
        check("rst_uart_tx1", uart_tx1, 1'b1);
        check("rst_tx_count", bus0.tx_count, 0);
        check("rst_tx_full", bus0.tx_full, 1'b0);
        check("rst_rx_empty", bus0.rx_empty, 1'b1);
        check("rst_rx_count", bus0.rx_count, 0);
        check("rst_rx_data", bus0.rx_data, 8'h00);
        check("rst_irq", bus0.irq, 1'b0);
        check("rst_errs", {bus0.frame_err, bus0.parity_err, bus0.overrun}, 3'b000);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // 1: loopback of four back-to-back frames, bit-exact line waveform
        bytes1 = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        push0(bytes1[0]);
        wait_tx_low("t1_start");
        push0(bytes1[1]);
        push0(bytes1[2]);
        push0(bytes1[3]);
        repeat (BIT_CLKS / 2 - 3) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            cur = bytes1[k / 10];
            if (k % 10 == 0)      exp_bit = 1'b0;
            else if (k % 10 == 9) exp_bit = 1'b1;
            else                  exp_bit = cur[k % 10 - 1];
            check($sformatf("t1_line_bit%0d", k), uart_tx0, exp_bit);
            repeat (BIT_CLKS) @(negedge clk);
        end
        check("t1_idle_after", uart_tx0, 1'b1);
        check("t1_rx_count", bus0.rx_count, 4);
        check("t1_irq", bus0.irq, 1'b1);
        check("t1_errs", {bus0.frame_err, bus0.parity_err, bus0.overrun}, 3'b000);
        pop_check0("t1_rx0", 8'h55);
        pop_check0("t1_rx1", 8'hA3);
        pop_check0("t1_rx2", 8'h00);
        pop_check0("t1_rx3", 8'hFF);
        check("t1_rx_empty", bus0.rx_empty, 1'b1);

        // 2+3: TX FIFO saturation while busy, then RX overrun from the five frames
        repeat (20) @(negedge clk);
        push0(8'h11);
        wait_tx_low("t2_start");
        push0(8'h22);
        push0(8'h33);
        push0(8'h44);
        push0(8'h55);
        push0(8'h66);
        check("t2_tx_count", bus0.tx_count, 4);
        check("t2_tx_full", bus0.tx_full, 1'b1);
        repeat (5 * 10 * BIT_CLKS + 40 - 5) @(negedge clk);
        check("t2_line_idle", uart_tx0, 1'b1);
        check("t2_tx_drained", bus0.tx_count, 0);
        check("t3_rx_count", bus0.rx_count, 4);
        check("t3_overrun", bus0.overrun, 1'b1);
        check("t3_irq", bus0.irq, 1'b1);
        check("t3_head", bus0.rx_data, 8'h11);
        check("t3_frame_err", bus0.frame_err, 1'b0);
        pulse_clr0();
        check("t3_ovr_clr", bus0.overrun, 1'b0);
        pop_check0("t3_rx0", 8'h11);
        pop_check0("t3_rx1", 8'h22);
        pop_check0("t3_rx2", 8'h33);
        pop_check0("t3_rx3", 8'h44);
        check("t3_rx_empty", bus0.rx_empty, 1'b1);

        // 4: framing error, glitch rejection, then a clean bench-driven frame
        drv0 = 1'b1;
        rx_src = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("t4_frame_err", bus0.frame_err, 1'b1);
        check("t4_rx_count", bus0.rx_count, 0);
        check("t4_irq_err", bus0.irq, 1'b1);
        pulse_clr0();
        @(negedge clk);
        check("t4_frame_clr", bus0.frame_err, 1'b0);
        check("t4_irq_clr", bus0.irq, 1'b0);
        drv0 = 1'b0;
        repeat (2 * OS_DIV) @(negedge clk);
        drv0 = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("t4_glitch_cnt", bus0.rx_count, 0);
        check("t4_glitch_ferr", bus0.frame_err, 1'b0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        check("t4_good_cnt", bus0.rx_count, 1);
        check("t4_good_data", bus0.rx_data, 8'hC3);

        // 5: even parity on dut1 (0x07 has three ones -> parity bit 1)
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        check("t5_par_err", bus1.parity_err, 1'b1);
        check("t5_dropped", bus1.rx_count, 0);
        check("t5_no_ferr", bus1.frame_err, 1'b0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("t5_good_cnt", bus1.rx_count, 1);
        check("t5_good_data", bus1.rx_data, 8'h07);

        // 6: reset while TX is in data bit 3 and RX in data bit 5
        a5 = 8'hA5;
        drv0 = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        drv0 = a5[0];
        repeat (BIT_CLKS) @(negedge clk);
        drv0 = a5[1];
        push0(8'h5A);
        push0(8'h96);
        repeat (BIT_CLKS - 2) @(negedge clk);
        for (int i = 2; i < 5; i++) begin
            drv0 = a5[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        drv0 = a5[5];
        repeat (20) @(negedge clk);
        check("t6_pre_tx_count", bus0.tx_count, 1);
        check("t6_pre_rx_count", bus0.rx_count, 1);
        reset = 1'b0;
        @(negedge clk);
        check("t6_uart_tx", uart_tx0, 1'b1);
        check("t6_tx_count", bus0.tx_count, 0);
        check("t6_tx_full", bus0.tx_full, 1'b0);
        check("t6_rx_count", bus0.rx_count, 0);
        check("t6_rx_empty", bus0.rx_empty, 1'b1);
        check("t6_rx_data", bus0.rx_data, 8'h00);
        check("t6_irq", bus0.irq, 1'b0);
        check("t6_par_err1", bus1.parity_err, 1'b0);
        check("t6_rx_count1", bus1.rx_count, 0);
        reset = 1'b1;
        drv0 = 1'b1;
        repeat (200) @(negedge clk);
        rx_src = 1'b0;
        push0(8'h69);
        repeat (720) @(negedge clk);
        check("t6_after_cnt", bus0.rx_count, 1);
        check("t6_after_data", bus0.rx_data, 8'h69);
        check("t6_after_errs", {bus0.frame_err, bus0.parity_err, bus0.overrun}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
